// File: rtl/dsm_pkg.sv
// -----------------------------------------------------------------------------
// dsm_pkg
// Shared constants and helpers for the parametrised MASH delta-sigma modulator.
//   - LFSR width and feedback tap positions of the dither generator
//   - legal bounds of the MASH order
//   - d_range(): signed range of the noise-cancellation offset for an order,
//     used to prove at elaboration that the output adder cannot wrap
// -----------------------------------------------------------------------------
package dsm_pkg;

    localparam int LFSR_W     = 17;
    localparam int LFSR_TAP_A = 17;    // x^17 + x^14 + 1
    localparam int LFSR_TAP_B = 14;

    localparam int ORDER_MIN  = 1;
    localparam int ORDER_MAX  = 3;

    typedef struct packed {
        int lo;
        int hi;
    } d_range_t;

    // Offset range of the cancellation network for a given order.
    function automatic d_range_t d_range(input int order);
        d_range_t r;
        case (order)
            1: begin r.lo =  0; r.hi = 1; end
            2: begin r.lo = -1; r.hi = 2; end
            default: begin r.lo = -3; r.hi = 4; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dsm_acc_stage.sv
// -----------------------------------------------------------------------------
// dsm_acc_stage
// One first-order error-feedback accumulator (modulo 2^FRAC_W).
//   clk, rst  : clock, asynchronous active-high reset
//   en_i      : 1 = accumulator advances
//   clr_i     : synchronous clear, overrides en_i
//   x_i       : stage input
//   cin_i     : extra LSB input (dither), absorbed into the same sum
//   c_o       : overflow carry of acc + x_i + cin_i (combinational)
//   sum_o     : wrapped sum, the next accumulator value and next stage input
// -----------------------------------------------------------------------------
module dsm_acc_stage #(
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [FRAC_W-1:0] x_i,
    input  logic              cin_i,
    output logic              c_o,
    output logic [FRAC_W-1:0] sum_o
);

    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   s;

    // acc + x + cin never exceeds 2^(FRAC_W+1)-1, so one extra bit suffices.
    assign s     = {1'b0, acc_q} + {1'b0, x_i} + {{FRAC_W{1'b0}}, cin_i};
    assign c_o   = s[FRAC_W];
    assign sum_o = s[FRAC_W-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= s[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/mash_dsm_param.sv
// -----------------------------------------------------------------------------
// mash_dsm_param
// Parametrised MASH 1-1(-1) delta-sigma modulator driving a fractional-N
// divider control word, one output per clock.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : 1 = modulator advances; 0 = all state and out hold
//   in_valid     : load request for in_i / in_f
//   in_ready     : 1 except in the cycle directly after a load
//   in_i, in_f   : integer part N and fractional part f
//   clr_on_load  : sampled with a load; zeroes accumulators and delay taps
//   out          : clamped modulated integer output
//   sat          : sticky clamp flag, cleared by rst or by a load
// Pipeline: active in_i/in_f -> stage (carries, in_i copy) -> out, so a new
// load value first shows on out two edges after the load edge.
// -----------------------------------------------------------------------------
module mash_dsm_param
    import dsm_pkg::*;
#(
    parameter int                FRAC_W    = 16,
    parameter int                INT_W     = 4,
    parameter int                ORDER     = 3,
    parameter int                DITHER_EN = 0,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 17'h1ACE5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INT_W-1:0]  in_i,
    input  logic [FRAC_W-1:0] in_f,
    input  logic              clr_on_load,
    output logic [INT_W-1:0]  out,
    output logic              sat
);

    localparam int       V_W     = INT_W + 2;
    localparam d_range_t D_RANGE = d_range(ORDER);

    // ---------------- elaboration checks ----------------
    if ((ORDER < ORDER_MIN) || (ORDER > ORDER_MAX)) begin : g_bad_order
        $error("mash_dsm_param: ORDER must be 1, 2 or 3");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("mash_dsm_param: LFSR_SEED must be non-zero");
    end
    if (((2**INT_W) - 1 + D_RANGE.hi >= 2**(INT_W+1)) ||
        (D_RANGE.lo < -(2**(INT_W+1)))) begin : g_bad_width
        $error("mash_dsm_param: INT_W too small for the offset range");
    end

    // ---------------- registers ----------------
    logic [INT_W-1:0]  in_i_q;
    logic [FRAC_W-1:0] in_f_q;
    logic              in_ready_q;
    logic [INT_W-1:0]  stage_i_q;          // in_i aligned with the stage carries
    logic [2:0]        c_q;                // c_k[n]   for k = 1..3
    logic [2:1]        c_d1_q;             // c_k[n-1] for k = 2..3
    logic              c_d2_q;             // c_3[n-2]
    logic [INT_W-1:0]  out_q, out_d;
    logic              sat_q, sat_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    logic load;
    logic clr;

    assign load     = in_valid && in_ready_q;
    assign clr      = load && clr_on_load;
    assign in_ready = in_ready_q;
    assign out      = out_q;
    assign sat      = sat_q;

    // ---------------- accumulator chain ----------------
    // Unused orders keep their carry at 0, so the single order-3 cancellation
    // formula below collapses to the order-1 and order-2 forms automatically.
    logic [ORDER_MAX-1:0] c;
    logic [FRAC_W-1:0]    x_chain [ORDER+1];
    logic [FRAC_W-1:0]    last_sum_unused;
    logic                 dither_bit;

    assign dither_bit      = (DITHER_EN != 0) ? lfsr_q[LFSR_W-1] : 1'b0;
    assign x_chain[0]      = in_f_q;
    assign last_sum_unused = x_chain[ORDER];

    for (genvar k = 0; k < ORDER_MAX; k++) begin : g_stage
        if (k < ORDER) begin : g_used
            dsm_acc_stage #(
                .FRAC_W (FRAC_W)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .en_i  (en),
                .clr_i (clr),
                .x_i   (x_chain[k]),
                .cin_i ((k == 0) ? dither_bit : 1'b0),
                .c_o   (c[k]),
                .sum_o (x_chain[k+1])
            );
        end else begin : g_unused
            assign c[k] = 1'b0;
        end
    end

    // ---------------- cancellation, output adder, clamp ----------------
    logic [V_W-1:0]   d;
    logic [V_W-1:0]   v;
    logic [INT_W-1:0] out_clamped;
    logic             clamp_hit;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        d = V_W'(c_q[0])
          + V_W'(c_q[1]) - V_W'(c_d1_q[1])
          + V_W'(c_q[2]) - (V_W'(c_d1_q[2]) << 1) + V_W'(c_d2_q);
        v = V_W'(stage_i_q) + d;

        out_clamped = v[INT_W-1:0];
        clamp_hit   = 1'b0;
        if (v[V_W-1]) begin
            out_clamped = '0;
            clamp_hit   = 1'b1;
        end else if (v[V_W-2:INT_W] != '0) begin
            out_clamped = '1;
            clamp_hit   = 1'b1;
        end

        out_d  = out_q;
        sat_d  = sat_q;
        lfsr_d = lfsr_q;
        if (en) begin
            out_d  = out_clamped;
            lfsr_d = {lfsr_q[LFSR_W-2:0],
                      lfsr_q[LFSR_TAP_A-1] ^ lfsr_q[LFSR_TAP_B-1]};
            if (clamp_hit) begin
                sat_d = 1'b1;
            end
        end
        // A load restarts the sticky flag, even if this edge also clamps.
        if (load) begin
            sat_d = 1'b0;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_i_q     <= '0;
            in_f_q     <= '0;
            in_ready_q <= 1'b1;
            stage_i_q  <= '0;
            c_q        <= '0;
            c_d1_q     <= '0;
            c_d2_q     <= 1'b0;
            out_q      <= '0;
            sat_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            // Ready drops for exactly one cycle after each accepted load.
            in_ready_q <= !load;
            if (load) begin
                in_i_q <= in_i;
                in_f_q <= in_f;
            end

            if (en) begin
                stage_i_q <= in_i_q;
            end

            if (clr) begin
                c_q    <= '0;
                c_d1_q <= '0;
                c_d2_q <= 1'b0;
            end else if (en) begin
                c_q    <= c;
                c_d1_q <= c_q[2:1];
                c_d2_q <= c_d1_q[2];
            end

            out_q  <= out_d;
            sat_q  <= sat_d;
            lfsr_q <= lfsr_d;
        end
    end

endmodule
